data_collector: RTL and testbench

DATA_COLLECTOR -- requirements
Module: data_collector

---
 rtl/data_collector_if.sv | 27 ++
 rtl/data_collector.sv | 103 ++++++++++
 tb/tb_data_collector.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_collector_if.sv
// Bundles the source-RAM read port and the downstream byte handshake of data_collector.
interface data_collector_if;
  logic [9:0] raddr;
  logic       read_en;
  logic [7:0] rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output raddr,
    output read_en,
    input  rdata,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  raddr,
    input  read_en,
    output rdata,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/data_collector.sv
// Streams a header byte followed by MESSAGE_LENGTH_BYTE bytes read from a block RAM
// to a valid/ready byte transmitter, one RAM read per payload byte.
module data_collector #(
  parameter int unsigned MESSAGE_LENGTH_BYTE = 859,
  parameter int unsigned BASE_ADDR           = 0,
  parameter logic [7:0]  HEADER_BYTE         = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_send,
  data_collector_if.master        bus,
  output logic                    busy,
  output logic                    done
);

  localparam logic [9:0] BASE10 = BASE_ADDR[9:0];
  localparam logic [9:0] LAST   = 10'(MESSAGE_LENGTH_BYTE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendHeader,
    StFetch,
    StWaitRam,
    StSendByte,
    StDone
  } state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [9:0] r_counter;
  logic [7:0] r_tx_data;
  logic       w_last;

  assign w_last = (r_counter == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:       if (start_send) w_state_next = StSendHeader;
      StSendHeader: if (bus.tx_ready) w_state_next = StFetch;
      StFetch:      w_state_next = StWaitRam;
      StWaitRam:    w_state_next = StSendByte;
      StSendByte:   if (bus.tx_ready) w_state_next = w_last ? StDone : StFetch;
      StDone:       w_state_next = StIdle;
      default:      w_state_next = StIdle;
    endcase
  end

  // Byte counter and the tx_data holding register; tx_data only changes outside
  // the two offering states, so it is stable across any stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_counter <= '0;
      r_tx_data <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_send) begin
            r_counter <= '0;
            r_tx_data <= HEADER_BYTE;
          end
        end
        StWaitRam: r_tx_data <= bus.rdata;
        StSendByte: begin
          if (bus.tx_ready && !w_last) r_counter <= r_counter + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are gated by rst_n so they read as idle for the whole reset window.
  always_comb begin
    bus.tx_valid = 1'b0;
    bus.read_en  = 1'b0;
    bus.raddr    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    if (rst_n) begin
      busy = (r_state != StIdle);
      unique case (r_state)
        StSendHeader, StSendByte: bus.tx_valid = 1'b1;
        StFetch: begin
          bus.read_en = 1'b1;
          bus.raddr   = BASE10 + r_counter;
        end
        StDone:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.tx_data = r_tx_data;

endmodule

// File: tb/tb_data_collector.sv
// Scoreboard bench for data_collector: a default-length instance and a LEN=1 instance
// at the top of the address space share one source RAM image.
module tb_data_collector;

  logic       clk;
  logic [1:0] rst_n;
  logic [1:0] start_send;
  logic [1:0] tx_ready;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] tx_valid_w;
  logic [1:0] read_en_w;
  logic [7:0] tx_data_w [2];

  logic [7:0] ram [1024];
  logic [7:0] exp_q [$];

  int cyc;
  int chk_cnt;
  int pass_cnt;
  int done_cnt;
  int xfer_cnt;
  bit spacing_chk;
  bit b2b_chk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LEN  = (g == 0) ? 859 : 1;
    localparam int unsigned BASE = (g == 0) ? 0 : 1023;

    data_collector_if u_if ();

    data_collector #(
      .MESSAGE_LENGTH_BYTE(LEN),
      .BASE_ADDR          (BASE),
      .HEADER_BYTE        (8'hA5)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .start_send(start_send[g]),
      .bus       (u_if),
      .busy      (busy[g]),
      .done      (done[g])
    );

    assign u_if.tx_ready = tx_ready[g];
    assign tx_valid_w[g] = u_if.tx_valid;
    assign read_en_w[g]  = u_if.read_en;
    assign tx_data_w[g]  = u_if.tx_data;

    always_ff @(posedge clk) begin
      if (u_if.read_en) u_if.rdata <= ram[u_if.raddr];
    end

    int         xfers;
    int         reads;
    int         last_cyc;
    int         last_done_cyc;
    bit         prev_stall;
    logic [7:0] prev_data;

    // Monitor: pops the scoreboard on each transfer and checks protocol timing.
    initial begin
      xfers = 0;
      reads = 0;
      last_cyc = 0;
      last_done_cyc = -1;
      prev_stall = 1'b0;
      prev_data = '0;
      forever begin
        @(negedge clk);
        if (!rst_n[g]) begin
          xfers = 0;
          reads = 0;
          prev_stall = 1'b0;
          last_done_cyc = -1;
        end else begin
          if (prev_stall) begin
            check("stall_valid", 32'(u_if.tx_valid), 32'd1);
            check("stall_data", 32'(u_if.tx_data), 32'(prev_data));
          end
          if (u_if.read_en) begin
            check("raddr", 32'(u_if.raddr), 32'(BASE + 32'(xfers) - 1));
            reads++;
          end
          if (u_if.tx_valid && u_if.tx_ready) begin
            check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("tx_data", 32'(u_if.tx_data), 32'(exp_q.pop_front()));
            if (spacing_chk && xfers > 0) check("byte_spacing", 32'(cyc - last_cyc), 32'd3);
            if (b2b_chk && xfers == 0 && last_done_cyc >= 0)
              check("b2b_gap", 32'(cyc - last_done_cyc), 32'd2);
            xfers++;
            xfer_cnt++;
            last_cyc = cyc;
          end
          prev_stall = u_if.tx_valid && !u_if.tx_ready;
          prev_data  = u_if.tx_data;
          if (done[g]) begin
            check("done_xfers", 32'(xfers), 32'(LEN + 1));
            check("done_reads", 32'(reads), 32'(LEN));
            check("done_timing", 32'(cyc), 32'(last_cyc + 1));
            done_cnt++;
            last_done_cyc = cyc;
            xfers = 0;
            reads = 0;
          end
        end
      end
    end
  end

  task automatic push_msg();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 859; i++) exp_q.push_back(8'(i));
  endtask

  // Waits until done_cnt reaches target; returns #1 after the edge that ends DONE.
  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_xfer(input int target);
    int n;
    n = 0;
    while (xfer_cnt < target && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("xfer_reached", 32'(xfer_cnt >= target), 32'd1);
  endtask

  task automatic pulse_start(input int g);
    start_send[g] = 1'b1;
    @(posedge clk);
    #1;
    start_send[g] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    ram[1023] = 8'h3C;
    rst_n = 2'b00;
    start_send = 2'b00;
    tx_ready = 2'b11;
    spacing_chk = 1'b0;
    b2b_chk = 1'b0;

    // Reset: outputs idle while held, start_send ignored.
    start_send = 2'b11;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_valid", 32'(tx_valid_w[g]), 32'd0);
      check("rst_read_en", 32'(read_en_w[g]), 32'd0);
      check("rst_busy", 32'(busy[g]), 32'd0);
      check("rst_done", 32'(done[g]), 32'd0);
    end
    @(posedge clk);
    #1;
    start_send = 2'b00;
    rst_n = 2'b11;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("idle_tx_data", 32'(tx_data_w[g]), 32'd0);
      check("idle_busy", 32'(busy[g]), 32'd0);
      check("idle_valid", 32'(tx_valid_w[g]), 32'd0);
    end

    // Nominal stream with tx_ready tied high, including header latency.
    push_msg();
    spacing_chk = 1'b1;
    @(posedge clk);
    #1;
    check("pre_start_valid", 32'(tx_valid_w[0]), 32'd0);
    pulse_start(0);
    check("hdr_latency_valid", 32'(tx_valid_w[0]), 32'd1);
    check("hdr_latency_data", 32'(tx_data_w[0]), 32'hA5);
    check("hdr_busy", 32'(busy[0]), 32'd1);
    wait_done(1);
    check("nominal_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("post_done_busy", 32'(busy[0]), 32'd0);
    spacing_chk = 1'b0;

    // Backpressure: tx_ready high about 30% of cycles.
    push_msg();
    pulse_start(0);
    for (int i = 0; i < 20000 && done_cnt < 2; i++) begin
      @(posedge clk);
      #1;
      tx_ready[0] = ($urandom_range(0, 9) < 3);
    end
    tx_ready[0] = 1'b1;
    check("bp_done", 32'(done_cnt), 32'd2);
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // start_send pulsed mid-payload is ignored.
    xfer_cnt = 0;
    push_msg();
    pulse_start(0);
    wait_xfer(101);
    pulse_start(0);
    wait_done(3);
    repeat (5) @(posedge clk);
    #1;
    check("ign_done_cnt", 32'(done_cnt), 32'd3);
    check("ign_q_empty", 32'(exp_q.size()), 32'd0);

    // start_send held high: two messages separated by DONE and IDLE.
    xfer_cnt = 0;
    push_msg();
    push_msg();
    spacing_chk = 1'b1;
    start_send[0] = 1'b1;
    wait_xfer(1);
    b2b_chk = 1'b1;
    wait_done(5);
    start_send[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    b2b_chk = 1'b0;
    spacing_chk = 1'b0;
    check("b2b_done_cnt", 32'(done_cnt), 32'd5);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_idle", 32'(busy[0]), 32'd0);

    // One-cycle reset after payload byte 50 aborts the message.
    xfer_cnt = 0;
    push_msg();
    pulse_start(0);
    wait_xfer(51);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(tx_valid_w[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_read_en", 32'(read_en_w[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("postrst_valid", 32'(tx_valid_w[0]), 32'd0);
    check("postrst_data", 32'(tx_data_w[0]), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("postrst_no_done", 32'(done_cnt), 32'd5);
    push_msg();
    pulse_start(0);
    wait_done(6);
    check("restart_q_empty", 32'(exp_q.size()), 32'd0);

    // LEN=1 at the last RAM address.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    pulse_start(1);
    wait_done(7);
    check("edge_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("edge_done_cnt", 32'(done_cnt), 32'd7);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
